// File: rtl/ukp_report_ctrl_if.sv
// Sequencer-side receive taps and consumer-side report port of the USB keyboard report controller.
// The master drives receive/consumer inputs; the slave (controller) drives report status.
interface ukp_report_ctrl_if;
  logic       rcv_connected;
  logic [7:0] rcv_data;
  logic [7:0] rcv_addr;
  logic       rcv_req;
  logic [2:0] rd_addr;
  logic [7:0] rd_data;
  logic       rpt_valid;
  logic       rpt_ack;
  logic [3:0] rpt_seq;
  logic       rpt_changed;
  logic       overrun;
  logic       timeout;
  logic [1:0] state_out;

  modport master (
    output rcv_connected, rcv_data, rcv_addr, rcv_req, rd_addr, rpt_ack,
    input  rd_data, rpt_valid, rpt_seq, rpt_changed, overrun, timeout, state_out
  );

  modport slave (
    input  rcv_connected, rcv_data, rcv_addr, rcv_req, rd_addr, rpt_ack,
    output rd_data, rpt_valid, rpt_seq, rpt_changed, overrun, timeout, state_out
  );
endinterface

// File: rtl/ukp_report_ctrl.sv
// Captures 8-byte HID reports from the USB sequencer's receive shift register,
// filters SYNC/DATA-toggle, double-buffers the report and tracks ack/overrun/timeout.
module ukp_report_ctrl (
  input  logic                usbclk,
  input  logic                reset_n,
  ukp_report_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    DISC = 2'd0,
    IDLE = 2'd1,
    RECV = 2'd2,
    DROP = 2'd3
  } state_t;

  localparam logic [7:0]  PID_SYNC   = 8'h80;
  localparam logic [7:0]  PID_DATA0  = 8'hC3;
  localparam logic [7:0]  PID_DATA1  = 8'h4B;
  localparam logic [15:0] IDLE_LIMIT = 16'd48000;

  state_t          state_q, state_d;
  logic [7:0]      last_addr_q;
  logic [7:0]      last_pid_q, pid_tmp_q;
  logic [7:0][7:0] front_q, shadow_q, front_new;
  logic [15:0]     idle_cnt_q;
  logic            rpt_valid_q, rpt_changed_q, overrun_q;
  logic [3:0]      rpt_seq_q;

  logic [4:0]      k;
  logic [2:0]      sh_idx;
  logic            ev, pid_ok, pid_latch, shadow_we, commit;

  // A byte boundary is a fresh multiple of 8 bits; repeated strobes at one address count once.
  assign k      = bus.rcv_addr[7:3];
  assign sh_idx = 3'(k - 5'd3);
  assign ev     = bus.rcv_req && (bus.rcv_addr[2:0] == 3'd0) && (k != 5'd0)
                  && (bus.rcv_addr != last_addr_q);
  assign pid_ok = ((bus.rcv_data == PID_DATA0) || (bus.rcv_data == PID_DATA1))
                  && (bus.rcv_data != last_pid_q);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    pid_latch = 1'b0;
    shadow_we = 1'b0;
    commit    = 1'b0;
    unique case (state_q)
      DISC: if (bus.rcv_connected) state_d = IDLE;
      IDLE: if (ev && k == 5'd1) state_d = (bus.rcv_data == PID_SYNC) ? RECV : DROP;
      RECV: begin
        if (bus.rcv_addr == 8'd0) begin
          state_d = IDLE;
        end else if (ev) begin
          if (k == 5'd2) begin
            if (pid_ok) pid_latch = 1'b1;
            else        state_d   = DROP;
          end else if (k >= 5'd3 && k <= 5'd10) begin
            shadow_we = 1'b1;
            if (k == 5'd10) begin
              commit  = 1'b1;
              state_d = IDLE;
            end
          end
        end
      end
      DROP: if (bus.rcv_addr == 8'd0) state_d = IDLE;
      default: state_d = DISC;
    endcase
    if (!bus.rcv_connected) begin
      state_d   = DISC;
      pid_latch = 1'b0;
      shadow_we = 1'b0;
      commit    = 1'b0;
    end
  end

  // The committed report is the shadow with byte 7 taken straight off the wire.
  always_comb begin
    front_new    = shadow_q;
    front_new[7] = bus.rcv_data;
  end

  always_ff @(posedge usbclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= DISC;
      last_addr_q <= 8'd0;
      idle_cnt_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      if (bus.rcv_addr == 8'd0) last_addr_q <= 8'd0;
      else if (ev)              last_addr_q <= bus.rcv_addr;
      if (state_q == DISC || ev)     idle_cnt_q <= 16'd0;
      else if (idle_cnt_q != IDLE_LIMIT) idle_cnt_q <= idle_cnt_q + 16'd1;
    end
  end

  // NOTE: the two 8-byte buffers are plain registers, so they take the async reset like any other state.
  always_ff @(posedge usbclk or negedge reset_n) begin
    if (!reset_n) begin
      front_q       <= '0;
      shadow_q      <= '0;
      last_pid_q    <= 8'd0;
      pid_tmp_q     <= 8'd0;
      rpt_valid_q   <= 1'b0;
      rpt_changed_q <= 1'b0;
      overrun_q     <= 1'b0;
      rpt_seq_q     <= 4'd0;
    end else begin
      if (pid_latch) pid_tmp_q <= bus.rcv_data;
      if (shadow_we) shadow_q[sh_idx] <= bus.rcv_data;
      if (!bus.rcv_connected) begin
        front_q     <= '0;
        shadow_q    <= '0;
        last_pid_q  <= 8'd0;
        rpt_valid_q <= 1'b0;
        overrun_q   <= 1'b0;
      end else if (commit) begin
        front_q       <= front_new;
        last_pid_q    <= pid_tmp_q;
        rpt_seq_q     <= rpt_seq_q + 4'd1;
        rpt_valid_q   <= 1'b1;
        rpt_changed_q <= (front_new != front_q);
        if (rpt_valid_q && !bus.rpt_ack) overrun_q <= 1'b1;
      end else if (bus.rpt_ack) begin
        rpt_valid_q <= 1'b0;
      end
    end
  end

  assign bus.rd_data     = front_q[bus.rd_addr];
  assign bus.rpt_valid   = rpt_valid_q;
  assign bus.rpt_seq     = rpt_seq_q;
  assign bus.rpt_changed = rpt_changed_q;
  assign bus.overrun     = overrun_q;
  assign bus.timeout     = (idle_cnt_q == IDLE_LIMIT) && (state_q != DISC);
  assign bus.state_out   = state_q;

endmodule

// File: tb/tb_ukp_report_ctrl.sv
// Directed bench for ukp_report_ctrl: a reference model predicts each committed report,
// which is queued at stimulus time and compared when the DUT's report counter advances.
module tb_ukp_report_ctrl;

  typedef struct packed {
    logic [3:0]      seq;
    logic            changed;
    logic [7:0][7:0] bytes;
  } exp_rpt_t;

  localparam logic [7:0] SYNC  = 8'h80;
  localparam logic [7:0] DATA0 = 8'hC3;
  localparam logic [7:0] DATA1 = 8'h4B;
  localparam logic [7:0] NAK   = 8'h5A;

  logic usbclk;
  logic reset_n;
  ukp_report_ctrl_if u_if ();

  ukp_report_ctrl dut (
    .usbclk  (usbclk),
    .reset_n (reset_n),
    .bus     (u_if.slave)
  );

  initial usbclk = 1'b0;
  always #40 usbclk = ~usbclk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  exp_rpt_t        exp_q[$];
  logic [7:0][7:0] m_front;
  logic [7:0]      m_last_pid;
  logic [3:0]      m_seq;
  logic            m_valid, m_overrun;
  logic [3:0]      seen_seq;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_front    = '0;
    m_last_pid = 8'd0;
    m_seq      = 4'd0;
    m_valid    = 1'b0;
    m_overrun  = 1'b0;
    seen_seq   = 4'd0;
  endtask

  task automatic send_byte(input logic [4:0] k, input logic [7:0] data, input logic ack);
    @(negedge usbclk);
    u_if.rcv_addr = {k, 3'b000};
    u_if.rcv_data = data;
    u_if.rcv_req  = 1'b1;
    u_if.rpt_ack  = ack;
    @(negedge usbclk);
    u_if.rcv_req  = 1'b0;
    u_if.rpt_ack  = 1'b0;
  endtask

  task automatic end_pkt();
    @(negedge usbclk);
    u_if.rcv_addr = 8'd0;
    @(negedge usbclk);
  endtask

  task automatic ack_pulse();
    @(negedge usbclk);
    u_if.rpt_ack = 1'b1;
    @(negedge usbclk);
    u_if.rpt_ack = 1'b0;
    m_valid = 1'b0;
  endtask

  // Full packet; 'dup' re-strobes byte 3's address twice with junk that must be ignored.
  task automatic send_packet(input logic [7:0] pid, input logic [7:0][7:0] bytes,
                             input logic ack_last, input logic dup);
    exp_rpt_t e;
    send_byte(5'd1, SYNC, 1'b0);
    send_byte(5'd2, pid, 1'b0);
    for (int b = 0; b < 8; b++) begin
      send_byte(5'(b + 3), bytes[b], ack_last && (b == 7));
      if (dup && b == 0) begin
        @(negedge usbclk); u_if.rcv_data = 8'h22; u_if.rcv_req = 1'b1;
        @(negedge usbclk); u_if.rcv_req  = 1'b0;
        @(negedge usbclk); u_if.rcv_data = 8'h33; u_if.rcv_req = 1'b1;
        @(negedge usbclk); u_if.rcv_req  = 1'b0;
      end
    end
    end_pkt();
    if ((pid == DATA0 || pid == DATA1) && pid != m_last_pid) begin
      e.changed  = (bytes != m_front);
      m_front    = bytes;
      m_last_pid = pid;
      m_seq      = m_seq + 4'd1;
      e.seq      = m_seq;
      e.bytes    = bytes;
      if (m_valid && !ack_last) m_overrun = 1'b1;
      m_valid    = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  task automatic check_front(input string tag);
    for (int b = 0; b < 8; b++) begin
      u_if.rd_addr = 3'(b);
      #1;
      chk(tag, 64'(u_if.rd_data), 64'(m_front[b]));
    end
  endtask

  task automatic check_report();
    exp_rpt_t e;
    logic got;
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      if (u_if.rpt_seq !== seen_seq) got = 1'b1;
      else @(negedge usbclk);
    end
    if (exp_q.size() == 0) begin
      chk("no_commit", 64'(got), 64'd0);
    end else begin
      e = exp_q.pop_front();
      chk("commit_seen", 64'(got), 64'd1);
      chk("rpt_seq", 64'(u_if.rpt_seq), 64'(e.seq));
      chk("rpt_changed", 64'(u_if.rpt_changed), 64'(e.changed));
      for (int b = 0; b < 8; b++) begin
        u_if.rd_addr = 3'(b);
        #1;
        chk("rd_data", 64'(u_if.rd_data), 64'(e.bytes[b]));
      end
    end
    seen_seq = u_if.rpt_seq;
  endtask

  task automatic check_status();
    chk("rpt_valid", 64'(u_if.rpt_valid), 64'(m_valid));
    chk("overrun", 64'(u_if.overrun), 64'(m_overrun));
    chk("rpt_seq_now", 64'(u_if.rpt_seq), 64'(m_seq));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_state"}, 64'(u_if.state_out), 64'd0);
    chk({tag, "_valid"}, 64'(u_if.rpt_valid), 64'd0);
    chk({tag, "_seq"}, 64'(u_if.rpt_seq), 64'd0);
    chk({tag, "_changed"}, 64'(u_if.rpt_changed), 64'd0);
    chk({tag, "_overrun"}, 64'(u_if.overrun), 64'd0);
    chk({tag, "_timeout"}, 64'(u_if.timeout), 64'd0);
    for (int b = 0; b < 8; b++) begin
      u_if.rd_addr = 3'(b);
      #1;
      chk({tag, "_rd_data"}, 64'(u_if.rd_data), 64'd0);
    end
  endtask

  initial begin
    logic got;
    logic [7:0] bv;

    reset_n            = 1'b0;
    u_if.rcv_connected = 1'b0;
    u_if.rcv_data      = 8'd0;
    u_if.rcv_addr      = 8'd0;
    u_if.rcv_req       = 1'b0;
    u_if.rd_addr       = 3'd0;
    u_if.rpt_ack       = 1'b0;
    model_reset();

    repeat (2) @(negedge usbclk);
    check_all_zero("reset");

    reset_n            = 1'b1;
    u_if.rcv_connected = 1'b1;
    @(negedge usbclk);
    chk("state_idle", 64'(u_if.state_out), 64'd1);

    // First report: byte 2 = 04
    send_packet(DATA0, 64'h0000_0000_0004_0000, 1'b0, 1'b0);
    check_report();
    check_status();
    u_if.rd_addr = 3'd2; #1;
    chk("rd_addr2", 64'(u_if.rd_data), 64'h04);

    // Repeated DATA0 toggle is dropped
    send_packet(DATA0, 64'h0000_0000_0004_0000, 1'b0, 1'b0);
    check_report();
    check_status();

    ack_pulse();
    check_status();
    ack_pulse();
    check_status();

    // Same bytes with DATA1: commits but unchanged
    send_packet(DATA1, 64'h0000_0000_0004_0000, 1'b0, 1'b0);
    check_report();
    check_status();

    // Commit coinciding with ack: valid stays, no overrun
    send_packet(DATA0, 64'h0000_0000_0506_0002, 1'b1, 1'b0);
    check_report();
    check_status();

    // NAK after SYNC goes to DROP and back to IDLE
    send_byte(5'd1, SYNC, 1'b0);
    send_byte(5'd2, NAK, 1'b0);
    chk("state_drop", 64'(u_if.state_out), 64'd3);
    send_byte(5'd3, 8'hEE, 1'b0);
    end_pkt();
    chk("drop_to_idle", 64'(u_if.state_out), 64'd1);
    check_report();
    check_front("nak_front");

    // Held byte-3 address, unacked report pending -> overrun
    send_packet(DATA1, 64'h0807_0605_0403_0211, 1'b0, 1'b1);
    check_report();
    check_status();

    // Abort mid-packet leaves the front report alone
    send_byte(5'd1, SYNC, 1'b0);
    send_byte(5'd2, DATA0, 1'b0);
    send_byte(5'd3, 8'hAA, 1'b0);
    send_byte(5'd4, 8'hBB, 1'b0);
    chk("state_recv", 64'(u_if.state_out), 64'd2);
    end_pkt();
    chk("abort_idle", 64'(u_if.state_out), 64'd1);
    check_report();
    check_status();
    check_front("abort_front");

    // Disconnect clears report state but not the counter
    @(negedge usbclk);
    u_if.rcv_connected = 1'b0;
    @(negedge usbclk);
    m_front = '0; m_last_pid = 8'd0; m_valid = 1'b0; m_overrun = 1'b0;
    chk("disc_state", 64'(u_if.state_out), 64'd0);
    check_status();
    check_front("disc_front");
    u_if.rcv_connected = 1'b1;
    @(negedge usbclk);
    chk("reconnect_idle", 64'(u_if.state_out), 64'd1);

    // Idle timeout
    repeat (47000) @(negedge usbclk);
    chk("timeout_early", 64'(u_if.timeout), 64'd0);
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge usbclk);
      if (u_if.timeout === 1'b1) got = 1'b1;
    end
    chk("timeout_set", 64'(got), 64'd1);
    send_byte(5'd1, SYNC, 1'b0);
    chk("timeout_clear", 64'(u_if.timeout), 64'd0);

    // Reset mid-RECV
    send_byte(5'd2, DATA0, 1'b0);
    send_byte(5'd3, 8'h55, 1'b0);
    chk("pre_reset_recv", 64'(u_if.state_out), 64'd2);
    reset_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    model_reset();
    @(negedge usbclk);
    u_if.rcv_addr = 8'd0;
    reset_n = 1'b1;
    @(negedge usbclk);

    // Sixteen commits: counter wraps 15 -> 0
    for (int i = 0; i < 16; i++) begin
      bv = 8'(i * 17);
      send_packet((i % 2 == 0) ? DATA0 : DATA1, {8{bv}}, 1'b1, 1'b0);
      check_report();
    end
    chk("seq_wrapped", 64'(u_if.rpt_seq), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
